// File: rtl/ialign_pkg.sv
// Shared types and helpers for the instruction align buffer: halfword type,
// the invalid-slot filler instruction and RISC-V compressed length detection.
package ialign_pkg;

  typedef logic [15:0] halfword_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Length in halfwords of the instruction whose low halfword is hw.
  function automatic logic [1:0] instr_len_hw(input halfword_t hw);
    return (hw[1:0] == 2'b11) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/ialign_slot_decode.sv
// One issue slot: length detect, instruction/PC assembly and the validity
// chain that makes a slot valid only when all of its halfwords are buffered.
module ialign_slot_decode
  import ialign_pkg::*;
#(
  parameter int OFF_W = 7
) (
  input  logic             prev_valid_i,
  input  halfword_t        hw_lo_i,
  input  halfword_t        hw_hi_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [OFF_W-1:0] avail_i,
  input  logic [31:0]      head_pc_i,
  output logic             valid_o,
  output logic [31:0]      instr_o,
  output logic [31:0]      pc_o,
  output logic             is16_o,
  output logic [OFF_W-1:0] next_off_o
);

  logic [1:0] len;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    len        = instr_len_hw(hw_lo_i);
    next_off_o = off_i + OFF_W'(len);
    valid_o    = prev_valid_i && (next_off_o <= avail_i);
    instr_o    = NOP_INSTR;
    pc_o       = '0;
    is16_o     = 1'b0;
    if (valid_o) begin
      is16_o  = (len == 2'd1);
      instr_o = is16_o ? {16'h0000, hw_lo_i} : {hw_hi_i, hw_lo_i};
      pc_o    = head_pc_i + (32'(off_i) << 1);
    end
  end

endmodule

// File: rtl/instr_align_buffer.sv
// Circular halfword buffer that realigns fetch packets into up to ISSUE
// 16/32-bit instruction slots per cycle, with flush and partial dequeue.
module instr_align_buffer
  import ialign_pkg::*;
#(
  parameter int FETCH_BYTES = 8,
  parameter int DEPTH_HW    = 16,
  parameter int ISSUE       = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         In_Valid,
  output logic                         In_Ready,
  input  logic [FETCH_BYTES*8-1:0]     In_Data,
  input  logic [31:0]                  In_PC,
  input  logic                         Flush,
  output logic [ISSUE-1:0]             Out_Valid,
  output logic [ISSUE*32-1:0]          Out_Instr,
  output logic [ISSUE*32-1:0]          Out_PC,
  output logic [ISSUE-1:0]             Out_16BitFlag,
  input  logic [$clog2(ISSUE+1)-1:0]   Deq_Cnt
);

  localparam int HPP    = FETCH_BYTES / 2;
  localparam int HOFF_W = $clog2(FETCH_BYTES);
  localparam int PTR_W  = $clog2(DEPTH_HW);
  localparam int CNT_W  = $clog2(DEPTH_HW + 1);
  localparam int OFF_W  = CNT_W + 2;

  halfword_t          mem_q [DEPTH_HW];
  halfword_t          wr_data [DEPTH_HW];
  logic [DEPTH_HW-1:0] wr_en;
  logic [PTR_W-1:0]   head_q, head_d, tail, wr_idx;
  logic [CNT_W-1:0]   count_q, count_d, enq_cnt;
  logic [31:0]        head_pc_q, head_pc_d;
  logic               rdy_en_q, rdy_en_d;
  logic [HOFF_W-2:0]  enq_off;
  logic               enq_fire;
  logic [OFF_W-1:0]   deq_hw;

  logic [ISSUE:0][OFF_W-1:0] slot_off;
  logic [ISSUE:0]            chain_valid;

  assign tail     = head_q + PTR_W'(count_q);
  assign enq_off  = In_PC[HOFF_W-1:1];
  assign enq_cnt  = CNT_W'(HPP) - CNT_W'(enq_off);
  // Ready is held low until the first edge after reset release.
  assign In_Ready = rdy_en_q && !Flush && ((CNT_W'(DEPTH_HW) - count_q) >= CNT_W'(HPP));
  assign enq_fire = In_Valid && In_Ready;

  assign slot_off[0]    = '0;
  assign chain_valid[0] = 1'b1;
  assign Out_Valid      = chain_valid[ISSUE:1];

  for (genvar g = 0; g < ISSUE; g++) begin : g_slot
    logic [PTR_W-1:0] lo_idx, hi_idx;
    assign lo_idx = head_q + slot_off[g][PTR_W-1:0];
    assign hi_idx = lo_idx + PTR_W'(1);

    ialign_slot_decode #(.OFF_W(OFF_W)) u_slot (
      .prev_valid_i (chain_valid[g]),
      .hw_lo_i      (mem_q[lo_idx]),
      .hw_hi_i      (mem_q[hi_idx]),
      .off_i        (slot_off[g]),
      .avail_i      (OFF_W'(count_q)),
      .head_pc_i    (head_pc_q),
      .valid_o      (chain_valid[g+1]),
      .instr_o      (Out_Instr[g*32 +: 32]),
      .pc_o         (Out_PC[g*32 +: 32]),
      .is16_o       (Out_16BitFlag[g]),
      .next_off_o   (slot_off[g+1])
    );
  end

  // Validity is prefix-monotone, so the last consumed valid slot's end offset
  // is the dequeue length; requests beyond the valid slots clamp naturally.
  always_comb begin
    deq_hw = '0;
    for (int k = 0; k < ISSUE; k++) begin
      if (k < int'(Deq_Cnt) && chain_valid[k+1]) deq_hw = slot_off[k+1];
    end
  end

  always_comb begin
    rdy_en_d  = 1'b1;
    head_d    = head_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;
    wr_en     = '0;
    wr_idx    = '0;
    for (int i = 0; i < DEPTH_HW; i++) wr_data[i] = '0;

    if (Flush) begin
      head_d  = tail;
      count_d = '0;
    end else begin
      head_d    = head_q + deq_hw[PTR_W-1:0];
      head_pc_d = head_pc_q + (32'(deq_hw) << 1);
      count_d   = count_q - deq_hw[CNT_W-1:0];
      if (enq_fire) begin
        count_d = count_d + enq_cnt;
        if (count_q == '0) head_pc_d = In_PC;
        for (int i = 0; i < HPP; i++) begin
          if (i >= int'(enq_off)) begin
            wr_idx          = tail + PTR_W'(i) - PTR_W'(enq_off);
            wr_en[wr_idx]   = 1'b1;
            wr_data[wr_idx] = In_Data[i*16 +: 16];
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      count_q   <= '0;
      head_pc_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      head_q    <= head_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

  // NOTE: the halfword array is not reset; count_q = 0 already marks every
  // entry as empty, and skipping the reset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH_HW; i++) begin
      if (wr_en[i]) mem_q[i] <= wr_data[i];
    end
  end

endmodule

// File: doc/instr_align_buffer.md
INSTR_ALIGN_BUFFER -- requirements
Module: instr_align_buffer

Interface
REQ-001 SHALL have parameter FETCH_BYTES, default 8, meaning fetch packet width in bytes (power of two, >=4).
REQ-002 SHALL have parameter DEPTH_HW, default 16, meaning buffer capacity in 16-bit halfwords (power of two, >= 2*FETCH_BYTES/2).
REQ-003 SHALL have parameter ISSUE, default 2, meaning output slots per cycle (1..4).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 In_Valid  in  1  fetch packet present; In_Ready  out  1  buffer can take a full packet.
REQ-007 In_Data  in  FETCH_BYTES*8  packet, little-endian halfwords; In_PC  in  32  PC of packet byte 0 plus halfword offset in bits [log2(FETCH_BYTES)-1:1].
REQ-008 Flush  in  1  discard all buffered halfwords (branch/exception redirect).
REQ-009 Out_Valid  out  ISSUE  per-slot valid; Out_Instr  out  ISSUE*32; Out_PC  out  ISSUE*32; Out_16BitFlag  out  ISSUE.
REQ-010 Deq_Cnt  in  clog2(ISSUE+1)  number of leading slots consumed this cycle.

Function
REQ-011 Storage SHALL be a circular halfword array with head pointer, count (0..DEPTH_HW) and Head_PC register; pointers wrap modulo DEPTH_HW.
REQ-012 In_Ready SHALL be 1 iff (DEPTH_HW - count) >= FETCH_BYTES/2 and Flush = 0, computed from registered count only.
REQ-013 On In_Valid & In_Ready, halfwords from offset In_PC[log2(FETCH_BYTES)-1:1] to end of packet SHALL be written at tail; count grows by that number next cycle.
REQ-014 If count = 0 (or after flush) at enqueue, Head_PC SHALL load In_PC; otherwise Head_PC is unchanged by enqueue.
REQ-015 Slot length: halfword with bits[1:0] != 2'b11 is a 16-bit instr (Out_Instr upper 16 bits zero, flag 1); else 32-bit using next halfword as upper half.
REQ-016 Slot k SHALL start at halfword head + sum of lengths of slots 0..k-1; Out_PC[k] = Head_PC + 2*that offset.
REQ-017 Slot k valid iff slot k-1 valid (k>0) and all its halfwords are buffered; a 32-bit instr with only its lower half present SHALL be invalid (straddle waits for next packet).
REQ-018 Outputs SHALL be combinational from registered state (zero-cycle read); enqueued data visible next cycle.
REQ-019 Deq_Cnt = d SHALL advance head and Head_PC by total length of slots 0..d-1 and reduce count accordingly; Deq_Cnt greater than number of valid slots SHALL be clamped to that number.
REQ-020 Simultaneous enqueue and dequeue SHALL update count by (enq halfwords - deq halfwords) in one cycle.
REQ-021 Flush SHALL take priority: next cycle count = 0, head = tail, all Out_Valid = 0; same-cycle enqueue and dequeue ignored.
REQ-022 Invalid slots SHALL drive Out_Instr = 32'h0000_0013, Out_PC = 0, flag 0.

Reset
REQ-023 While rst_n = 0: count = 0, head = tail = 0, Head_PC = 0, In_Ready = 0, Out_Valid = 0; In_Ready rises the first cycle after release.
REQ-024 Reset asserted mid-operation SHALL discard buffered halfwords immediately without waiting for a clock edge.

Structure
REQ-025 Package ialign_pkg SHALL hold NOP constant, halfword typedef, and length-detect function; default parameters stay on the module.
REQ-026 One sub-module ialign_slot_decode (per-slot length detect, instr/PC assembly) SHALL be instantiated ISSUE times via generate.

Verification
REQ-027 Packet 64'h57c157c1_00000013 at PC 0 -> slot0 00000013/PC 0/flag 0, slot1 000057c1/PC 4/flag 1; Deq_Cnt=2 -> next cycle slot0 000057c1/PC 6.
REQ-028 Packet halfwords {0013,57c1,57c1,57c1} (hi..lo) at PC 0, no second packet -> three 16-bit slots over time, 4th slot (lower half of 32-bit at PC 6) never valid; after packet {..,0000} -> 00000013 at PC 6.
REQ-029 In_PC = 0x0000_000C with FETCH_BYTES=8 -> only halfwords 2,3 enqueued, count=2, slot0 PC 0xC.
REQ-030 Fill until count > DEPTH_HW-4 -> In_Ready=0; Deq_Cnt frees space -> In_Ready=1 next cycle; head wrap past DEPTH_HW keeps instr/PC order correct.
REQ-031 Flush with In_Valid and Deq_Cnt=2 same cycle -> next cycle count=0, Out_Valid=0; following packet at 0x100 -> slot0 PC 0x100.
REQ-032 rst_n low with 6 halfwords buffered -> Out_Valid=0 immediately, In_Ready=0 until release.
